aplic_irq_filter: RTL and testbench
===================================

// Module: aplic_irq_filter
// PURPOSE
// - Conditions raw wired interrupt lines before they reach the APLIC domain logic.
// - Sits directly upstream of the APLIC top; its output drives that block's i_irq_sources.
// - Per source: synchronise into i_clk, then debounce. A level change is forwarded only
//   after it has been stable for a programmable number of cycles.
// - Aborted changes are flagged as glitches.
// PARAMETERS
// - NR_SRC       32  number of source lines; source 0 is reserved and always 0.
// - SYNC_STAGES  2   synchroniser depth; legal range 2..4.
// - FILT_W       4   width of the debounce counter and of i_filt_len.
// PORTS
// - i_clk            in   1            clock; all logic on the rising edge.
// - i_rst            in   1            reset; synchronous, active-high.
// - i_irq_raw        in   NR_SRC       asynchronous raw interrupt lines.
// - i_filt_len       in   FILT_W       stability requirement L, in cycles; quasi-static.
// - o_irq_sources    out  NR_SRC       filtered levels, to APLIC i_irq_sources.
// - o_glitch         out  NR_SRC       1-cycle pulse per source on an aborted change.
// - o_glitch_cnt     out  16           glitch event counter; only with APLIC_IRQ_FILTER_STAT_EN.
// - i_glitch_clr     in   1            clears o_glitch_cnt; only with APLIC_IRQ_FILTER_STAT_EN.
// BEHAVIOUR
// - Reset: synchroniser flops, stable value s[i], counter c[i], o_irq_sources,
//   o_glitch and o_glitch_cnt are all 0.
// - Reset asserted mid-debounce discards the pending change. Reset is sampled on the clock edge only.
// - Synchroniser: x[i] is i_irq_raw[i] after SYNC_STAGES flops. Bit 0 is tied to 0 before the chain.
// - Per source, each cycle, in priority order:
//   - x == s: set c to 0. If c != 0, pulse o_glitch[i] on the next cycle.
//   - x != s and c >= i_filt_len: set s to x and c to 0.
//   - otherwise: increment c.
// - The >= comparison covers a decrease of L while a count is in flight: that source
//   commits on the next cycle.
// - c never exceeds 2^FILT_W-1, because commit occurs at c >= L and L <= 2^FILT_W-1. No wrap.
// - o_irq_sources = s, registered. o_glitch is registered, so it is high exactly 1 cycle per event.
// - Latency: a clean change on i_irq_raw reaches o_irq_sources after SYNC_STAGES + L + 1 edges.
// - L = 0: the filter is a 1-cycle register stage.
// - A change shorter than L + 1 sampled cycles never propagates and produces one o_glitch pulse.
// - Sources are independent. Simultaneous events on several sources are all handled in the same cycle.
// - Bit 0: o_irq_sources[0] = 0 and o_glitch[0] = 0 permanently.
// - No handshake. The downstream block samples levels every cycle.
// CONFIGURATION
// - Macro APLIC_IRQ_FILTER_STAT_EN defined:
//   - Adds ports o_glitch_cnt and i_glitch_clr.
//   - Each cycle: cnt <= sat16(cnt + popcount(o_glitch_next)), saturating at 16'hFFFF.
//   - i_glitch_clr has priority: cnt <= 0 even if glitches occur in the same cycle.
// - Macro not defined: the ports are absent, no counter logic exists, and all other behaviour is identical.
// TESTING
// - Reset, L=3, i_irq_raw=0 for 10 cycles: all outputs 0. Then raw[5]=1 held:
//   o_irq_sources[5] rises exactly 2+3+1=6 edges after the sampling edge.
// - L=3, raw[7] high for 2 cycles then low: o_irq_sources[7] stays 0, o_glitch[7] pulses once for 1 cycle.
// - L=0, raw toggles every 4 cycles: o_irq_sources tracks with 3-edge latency and o_glitch stays 0.
// - raw[0] toggled freely: o_irq_sources[0] and o_glitch[0] stay 0. raw=32'hFFFF_FFFE with L=2:
//   all bits 31..1 rise on the same cycle.
// - L=15, raw[3]=1 held; after 10 cycles set L=4: bit 3 commits on the next cycle.
//   i_rst mid-count: s=0, c=0, and the count restarts.
// - STAT_EN: 3 sources glitch in one cycle: cnt += 3. cnt=16'hFFFE plus 2 glitches: 16'hFFFF.
//   i_glitch_clr with a concurrent glitch: cnt = 0.

Source files
------------

// File: rtl/aplic_irq_filter.sv
// Raw interrupt conditioner for the APLIC: per-source synchroniser plus debounce filter.
// Optional glitch statistics counter enabled by defining APLIC_IRQ_FILTER_STAT_EN.
module aplic_irq_filter #(
  parameter int unsigned NR_SRC      = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NR_SRC-1:0] i_irq_raw,
  input  logic [FILT_W-1:0] i_filt_len,
  output logic [NR_SRC-1:0] o_irq_sources,
  output logic [NR_SRC-1:0] o_glitch
`ifdef APLIC_IRQ_FILTER_STAT_EN
  ,
  output logic [15:0]       o_glitch_cnt,
  input  logic              i_glitch_clr
`endif
);

  localparam int unsigned PopW = $clog2(NR_SRC + 1);

  logic [NR_SRC-1:0] raw_masked;
  logic [NR_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NR_SRC-1:0] x;
  logic [NR_SRC-1:0] s_q, s_d;
  logic [NR_SRC-1:0] glitch_q, glitch_d;
  logic [FILT_W-1:0] cnt_q [NR_SRC];
  logic [FILT_W-1:0] cnt_d [NR_SRC];

  // Source 0 is reserved: force it low ahead of the synchroniser.
  assign raw_masked = i_irq_raw & ~NR_SRC'(1);
  assign x          = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw_masked;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    s_d      = s_q;
    glitch_d = '0;
    for (int i = 0; i < NR_SRC; i++) begin
      cnt_d[i] = cnt_q[i];
      if (x[i] == s_q[i]) begin
        cnt_d[i]    = '0;
        glitch_d[i] = (cnt_q[i] != '0);
      end else if (cnt_q[i] >= i_filt_len) begin
        // >= so that lowering the filter length mid-count commits promptly.
        s_d[i]   = x[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + FILT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s_q      <= '0;
      glitch_q <= '0;
      for (int i = 0; i < NR_SRC; i++) cnt_q[i] <= '0;
    end else begin
      s_q      <= s_d;
      glitch_q <= glitch_d;
      for (int i = 0; i < NR_SRC; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign o_irq_sources = s_q;
  assign o_glitch      = glitch_q;

`ifdef APLIC_IRQ_FILTER_STAT_EN
  logic [PopW-1:0] pop;
  logic [16:0]     sum;
  logic [15:0]     gcnt_q, gcnt_d;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NR_SRC; i++) pop = pop + PopW'(glitch_d[i]);
    sum = 17'(gcnt_q) + 17'(pop);
    if (i_glitch_clr) begin
      gcnt_d = '0;
    end else if (sum[16]) begin
      gcnt_d = 16'hFFFF;
    end else begin
      gcnt_d = sum[15:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
    end
  end

  assign o_glitch_cnt = gcnt_q;
`endif

endmodule

// File: tb/tb_aplic_irq_filter.sv
// Directed self-checking bench for aplic_irq_filter (NR_SRC=32, SYNC_STAGES=2, FILT_W=4).
module tb_aplic_irq_filter;

  logic        clk;
  logic        rst;
  logic [31:0] raw;
  logic [3:0]  filt_len;
  logic [31:0] irq_sources;
  logic [31:0] glitch;
`ifdef APLIC_IRQ_FILTER_STAT_EN
  logic [15:0] glitch_cnt;
  logic        glitch_clr;
`endif

  int checks = 0;
  int errors = 0;

  aplic_irq_filter #(
    .NR_SRC      (32),
    .SYNC_STAGES (2),
    .FILT_W      (4)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_irq_raw     (raw),
    .i_filt_len    (filt_len),
    .o_irq_sources (irq_sources),
    .o_glitch      (glitch)
`ifdef APLIC_IRQ_FILTER_STAT_EN
    ,
    .o_glitch_cnt  (glitch_cnt),
    .i_glitch_clr  (glitch_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] seen_or;
    rst = 1'b1; raw = '0; filt_len = 4'd3;
`ifdef APLIC_IRQ_FILTER_STAT_EN
    glitch_clr = 1'b0;
`endif
    tick(2);
    rst = 1'b0;
    checks++;
    if (irq_sources !== 32'h0) begin
      errors++; $display("FAIL reset_sources: got %h want %h", irq_sources, 32'h0);
    end
    checks++;
    if (glitch !== 32'h0) begin
      errors++; $display("FAIL reset_glitch: got %h want %h", glitch, 32'h0);
    end
`ifdef APLIC_IRQ_FILTER_STAT_EN
    checks++;
    if (glitch_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_cnt: got %h want %h", glitch_cnt, 16'h0);
    end
`endif
    seen_or = '0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      seen_or = seen_or | irq_sources | glitch;
    end
    checks++;
    if (seen_or !== 32'h0) begin
      errors++; $display("FAIL idle_outputs: got %h want %h", seen_or, 32'h0);
    end
  endtask

  task automatic test_latency;
    filt_len = 4'd3;
    raw = 32'h0000_0020;
    tick(5);
    checks++;
    if (irq_sources !== 32'h0) begin
      errors++; $display("FAIL latency_early: got %h want %h", irq_sources, 32'h0);
    end
    tick(1);
    checks++;
    if (irq_sources !== 32'h0000_0020) begin
      errors++; $display("FAIL latency_edge6: got %h want %h", irq_sources, 32'h20);
    end
    raw = '0;
    tick(8);
    checks++;
    if (irq_sources !== 32'h0) begin
      errors++; $display("FAIL latency_fall: got %h want %h", irq_sources, 32'h0);
    end
  endtask

  task automatic test_glitch;
    int pulses;
    logic rose;
    filt_len = 4'd3;
    raw = 32'h0000_0080;
    tick(2);
    raw = '0;
    pulses = 0; rose = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (glitch[7]) pulses++;
      if (irq_sources[7]) rose = 1'b1;
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL glitch_pulse_cycles: got %0d want %0d", pulses, 1);
    end
    checks++;
    if (rose !== 1'b0) begin
      errors++; $display("FAIL glitch_no_commit: got %b want %b", rose, 1'b0);
    end
  endtask

  task automatic test_l0;
    logic [2:0] hist;
    logic       gl_seen;
    filt_len = 4'd0;
    hist = '0; gl_seen = 1'b0;
    for (int k = 0; k < 24; k++) begin
      raw = {19'b0, 1'(((k / 4) % 2) == 1), 12'b0};
      tick(1);
      hist = {hist[1:0], raw[12]};
      if (glitch != 32'h0) gl_seen = 1'b1;
      if (k >= 3) begin
        checks++;
        if (irq_sources !== {19'b0, hist[2], 12'b0}) begin
          errors++;
          $display("FAIL l0_track k=%0d: got %h want %h", k, irq_sources,
                   {19'b0, hist[2], 12'b0});
        end
      end
    end
    raw = '0;
    tick(4);
    checks++;
    if (gl_seen !== 1'b0) begin
      errors++; $display("FAIL l0_no_glitch: got %b want %b", gl_seen, 1'b0);
    end
  endtask

  task automatic test_bit0_and_all;
    logic [31:0] seen_or;
    filt_len = 4'd2;
    seen_or = '0;
    for (int k = 0; k < 10; k++) begin
      raw = {31'b0, 1'(k % 2)};
      tick(1);
      seen_or = seen_or | irq_sources | glitch;
    end
    raw = '0;
    tick(4);
    seen_or = seen_or | irq_sources | glitch;
    checks++;
    if (seen_or !== 32'h0) begin
      errors++; $display("FAIL bit0_ignored: got %h want %h", seen_or, 32'h0);
    end
    raw = 32'hFFFF_FFFE;
    tick(4);
    checks++;
    if (irq_sources !== 32'h0) begin
      errors++; $display("FAIL all_early: got %h want %h", irq_sources, 32'h0);
    end
    tick(1);
    checks++;
    if (irq_sources !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL all_same_cycle: got %h want %h", irq_sources, 32'hFFFF_FFFE);
    end
    raw = '0;
    tick(8);
  endtask

  task automatic test_l_decrease;
    filt_len = 4'd15;
    raw = 32'h0000_0008;
    tick(10);
    checks++;
    if (irq_sources !== 32'h0) begin
      errors++; $display("FAIL ldec_before: got %h want %h", irq_sources, 32'h0);
    end
    filt_len = 4'd4;
    tick(1);
    checks++;
    if (irq_sources !== 32'h0000_0008) begin
      errors++; $display("FAIL ldec_commit: got %h want %h", irq_sources, 32'h8);
    end
    raw = '0;
    tick(10);
  endtask

  task automatic test_reset_mid;
    filt_len = 4'd3;
    raw = 32'h0000_0200;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if ({irq_sources, glitch} !== 64'h0) begin
      errors++; $display("FAIL rstmid_clear: got %h want %h", {irq_sources, glitch}, 64'h0);
    end
    tick(5);
    checks++;
    if (irq_sources !== 32'h0) begin
      errors++; $display("FAIL rstmid_early: got %h want %h", irq_sources, 32'h0);
    end
    tick(1);
    checks++;
    if (irq_sources !== 32'h0000_0200) begin
      errors++; $display("FAIL rstmid_restart: got %h want %h", irq_sources, 32'h200);
    end
    raw = '0;
    tick(8);
  endtask

`ifdef APLIC_IRQ_FILTER_STAT_EN
  task automatic test_stat;
    logic gl_seen;
    glitch_clr = 1'b1;
    tick(1);
    glitch_clr = 1'b0;
    checks++;
    if (glitch_cnt !== 16'h0) begin
      errors++; $display("FAIL stat_clear: got %h want %h", glitch_cnt, 16'h0);
    end
    filt_len = 4'd3;
    raw = 32'h0000_0054;
    tick(2);
    raw = '0;
    tick(8);
    checks++;
    if (glitch_cnt !== 16'd3) begin
      errors++; $display("FAIL stat_three: got %h want %h", glitch_cnt, 16'd3);
    end
    glitch_clr = 1'b1;
    tick(1);
    glitch_clr = 1'b0;
    // 2114 single-cycle pulses on 31 sources give exactly 16'hFFFE events.
    filt_len = 4'd1;
    for (int k = 0; k < 2114; k++) begin
      raw = 32'hFFFF_FFFE;
      tick(1);
      raw = '0;
      tick(1);
    end
    tick(6);
    checks++;
    if (glitch_cnt !== 16'hFFFE) begin
      errors++; $display("FAIL stat_fffe: got %h want %h", glitch_cnt, 16'hFFFE);
    end
    filt_len = 4'd3;
    raw = 32'h0000_0014;
    tick(2);
    raw = '0;
    tick(8);
    checks++;
    if (glitch_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL stat_saturate: got %h want %h", glitch_cnt, 16'hFFFF);
    end
    glitch_clr = 1'b1;
    gl_seen = 1'b0;
    raw = 32'h0000_0004;
    tick(2);
    raw = '0;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      if (glitch[2]) gl_seen = 1'b1;
    end
    glitch_clr = 1'b0;
    checks++;
    if (gl_seen !== 1'b1) begin
      errors++; $display("FAIL stat_clr_glitch_seen: got %b want %b", gl_seen, 1'b1);
    end
    tick(1);
    checks++;
    if (glitch_cnt !== 16'h0) begin
      errors++; $display("FAIL stat_clr_priority: got %h want %h", glitch_cnt, 16'h0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_l0();
    test_bit0_and_all();
    test_l_decrease();
    test_reset_mid();
`ifdef APLIC_IRQ_FILTER_STAT_EN
    test_stat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
